ko4_mul_seq: RTL and testbench

KO4_MUL_SEQ -- requirements
Module: ko4_mul_seq

---
 rtl/ko4_mul_seq_pkg.sv | 23 ++
 rtl/ko4_limb_mul.sv | 25 ++
 rtl/ko_mul_split.sv | 13 +
 rtl/ko4_mul_seq.sv | 113 +++++++++++
 tb/tb_ko4_mul_seq.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/ko4_mul_seq_pkg.sv
// ko4_mul_seq_pkg: shared sizing constants, FSM encoding and cross-pair table for the KO4 multiplier
// Holds the default DATA_WIDTH / KO_PARAMETER, the derived limb width LW and the state type.
package ko4_mul_seq_pkg;
    localparam int DEF_DATA_WIDTH   = 72;
    localparam int DEF_KO_PARAMETER = 4;

    function automatic int ko_lw(input int dw, input int n);
        return dw / n;
    endfunction

    localparam int LW = ko_lw(DEF_DATA_WIDTH, DEF_KO_PARAMETER);

    typedef enum logic [1:0] {IDLE, DIAG, CROSS, DONE} state_e;

    // Cross pair c (0..5) packed as {i, j}; order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3)
    function automatic logic [3:0] ko_pair(input logic [3:0] c);
        return c == 4'd0 ? 4'b00_01 :
               c == 4'd1 ? 4'b00_10 :
               c == 4'd2 ? 4'b00_11 :
               c == 4'd3 ? 4'b01_10 :
               c == 4'd4 ? 4'b01_11 : 4'b10_11;
    endfunction
endpackage

// File: rtl/ko4_limb_mul.sv
// ko4_limb_mul: shared unsigned (LW+1)x(LW+1) multiplier for the KO4 sub-products
// Ports: clk_i/rst_ni clock and async active-low reset, a_i/b_i factors, p_o product.
// KO_MUL_PIPE_EN: when defined the product is registered (one cycle of latency).
module ko4_limb_mul #(
    parameter int W = 19
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);
    logic [2*W-1:0] p;
    assign p = a_i * b_i;
`ifdef KO_MUL_PIPE_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) p_o <= '0;
        else         p_o <= p;
    end
`else
    logic unused_clk;
    assign unused_clk = clk_i ^ rst_ni;
    assign p_o = p;
`endif
endmodule

// File: rtl/ko_mul_split.sv
// ko_mul_split: cuts an operand into four equal limbs, limb 0 holding the LSBs
// Ports: x_i operand in, limbs_o four LW-bit limbs out.
module ko_mul_split #(
    parameter int DATA_WIDTH = 72,
    parameter int LW         = 18
) (
    input  logic [DATA_WIDTH-1:0] x_i,
    output logic [3:0][LW-1:0]    limbs_o
);
    for (genvar i = 0; i < 4; i++) begin : g_limb
        assign limbs_o[i] = x_i[i*LW +: LW];
    end
endmodule

// File: rtl/ko4_mul_seq.sv
// ko4_mul_seq: sequential 4-limb Karatsuba-Ofman multiplier sharing one limb multiplier over 10 steps
// Ports: clk, rst_n (async active-low), in_valid/in_ready + mul_a/mul_b operand handshake,
//        out_valid/out_ready + product result handshake.
// KO_MUL_PIPE_EN: registers the shared multiplier output; adds one drain step (latency 12 vs 11).
module ko4_mul_seq
    import ko4_mul_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int KO_PARAMETER = DEF_KO_PARAMETER
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   mul_a,
    input  logic [DATA_WIDTH-1:0]   mul_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] product
);
    localparam int L  = ko_lw(DATA_WIDTH, KO_PARAMETER);
    localparam int PL = 2*L + 2;
    localparam int PW = 2*DATA_WIDTH;
`ifdef KO_MUL_PIPE_EN
    localparam logic [3:0] LAST = 4'd10;
`else
    localparam logic [3:0] LAST = 4'd9;
`endif
    state_e              state_q;
    logic [3:0]          step_q;
    logic [3:0][L-1:0]   a_l, b_l, a_q, b_q;
    logic [3:0][2*L-1:0] d_q;
    logic [PW-1:0]       acc_q, acc_d;
    logic [L:0]          ma, mb;
    logic [PL-1:0]       p, term;
    logic [3:0]          pi, pa, idx;
    logic [2:0]          sh;
    logic                busy, acc_en;

    ko_mul_split #(.DATA_WIDTH(DATA_WIDTH), .LW(L)) u_split_a (.x_i(mul_a), .limbs_o(a_l));
    ko_mul_split #(.DATA_WIDTH(DATA_WIDTH), .LW(L)) u_split_b (.x_i(mul_b), .limbs_o(b_l));
    ko4_limb_mul #(.W(L+1)) u_mul (.clk_i(clk), .rst_ni(rst_n), .a_i(ma), .b_i(mb), .p_o(p));

    // Issue side: steps 0..3 are diagonal limbs, steps 4..9 are limb-pair sums
    always_comb begin
        pi = ko_pair(step_q - 4'd4);
        ma = step_q < 4'd4 ? {1'b0, a_q[step_q[1:0]]} : {1'b0, a_q[pi[3:2]]} + {1'b0, a_q[pi[1:0]]};
        mb = step_q < 4'd4 ? {1'b0, b_q[step_q[1:0]]} : {1'b0, b_q[pi[3:2]]} + {1'b0, b_q[pi[1:0]]};
    end

    // Accumulate side: idx is the step whose multiplier result is currently on p
    always_comb begin
        busy = state_q == DIAG || state_q == CROSS;
`ifdef KO_MUL_PIPE_EN
        idx    = step_q - 4'd1;
        acc_en = busy && step_q != 4'd0;
`else
        idx    = step_q;
        acc_en = busy;
`endif
        pa    = ko_pair(idx - 4'd4);
        term  = idx < 4'd4 ? p : p - PL'(d_q[pa[3:2]]) - PL'(d_q[pa[1:0]]);
        sh    = idx < 4'd4 ? {idx[1:0], 1'b0} : {1'b0, pa[3:2]} + {1'b0, pa[1:0]};
        acc_d = acc_q + (PW'(term) << (int'(sh) * L));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            d_q       <= '0;
            acc_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            if (acc_en) acc_q <= acc_d;
            if (acc_en && idx < 4'd4) d_q[idx[1:0]] <= p[2*L-1:0];
            case (state_q)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= a_l;
                        b_q      <= b_l;
                        acc_q    <= '0;
                        step_q   <= '0;
                        in_ready <= 1'b0;
                        state_q  <= DIAG;
                    end
                end
                DIAG: begin
                    step_q <= step_q + 4'd1;
                    if (step_q == 4'd3) state_q <= CROSS;
                end
                CROSS: begin
                    step_q <= step_q + 4'd1;
                    if (step_q == LAST) state_q <= DONE;
                end
                DONE: begin
                    out_valid <= 1'b1;
                    product   <= acc_q;
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ko4_mul_seq.sv
// tb_ko4_mul_seq: scoreboard bench for ko4_mul_seq (directed vectors plus random back-to-back pairs)
module tb_ko4_mul_seq;
`ifdef KO_MUL_PIPE_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 11;
`endif
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [71:0]  mul_a = '0;
    logic [71:0]  mul_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [143:0] product;

    logic [143:0] exp_q[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_acc = 0;

    ko4_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mul_a(mul_a), .mul_b(mul_b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [143:0] got, input logic [143:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    always @(posedge clk) if (rst_n && in_valid && in_ready) n_acc++;

    // Monitor: every completed output handshake pops one expected product
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", 144'd1, 144'd0);
            else chk("product", product, exp_q.pop_front());
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
        if (!in_ready) chk("in_ready_timeout", 144'(in_ready), 144'd1);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 60 && !out_valid; i++) @(negedge clk);
        if (!out_valid) chk("out_valid_timeout", 144'(out_valid), 144'd1);
    endtask

    // Drives one operand pair; returns after the accepting edge with in_valid still high
    task automatic accept(input logic [71:0] a, input logic [71:0] b, input logic [143:0] e, input bit push);
        mul_a = a;
        mul_b = b;
        in_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1;
    endtask

    task automatic issue(input logic [71:0] a, input logic [71:0] b, input logic [143:0] e, input bit push);
        accept(a, b, e, push);
        in_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int acc0;
        int seen;
        logic [95:0] ra, rb;
        // reset values
        #2;
        chk("rst_in_ready", 144'(in_ready), 144'd0);
        chk("rst_out_valid", 144'(out_valid), 144'd0);
        chk("rst_product", product, 144'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_reset", 144'(in_ready), 144'd1);

        // 1*1 with latency measurement
        issue(72'd1, 72'd1, 144'd1, 1'b1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 144'(lat), 144'(LAT));
        wait (exp_q.size() == 0 || !rst_n);

        // all-ones operands: 2^144 - 2^73 + 1
        issue({72{1'b1}}, {72{1'b1}}, {{71{1'b1}}, {72{1'b0}}, 1'b1}, 1'b1);
        wait_out();
        @(posedge clk); #1;

        // zero operand with in_valid held high for the whole operation
        wait_ready();
        acc0 = n_acc;
        accept(72'd0, 72'h5A5A5A5A5A5A5A5A5A, 144'd0, 1'b1);
        wait_out();
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("single_accept", 144'(n_acc - acc0), 144'd1);

        // backpressure in DONE
        out_ready = 1'b0;
        issue(72'h123, 72'h456, 144'h4EDC2, 1'b1);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 144'(out_valid), 144'd1);
            chk("bp_product", product, 144'h4EDC2);
            chk("bp_in_ready", 144'(in_ready), 144'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in_ready_after_release", 144'(in_ready), 144'd1);

        // reset pulse mid-operation aborts the result
        issue(72'd7, 72'd9, 144'd63, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_out_valid", 144'(out_valid), 144'd0);
        chk("midrst_in_ready", 144'(in_ready), 144'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("aborted_no_output", 144'(seen), 144'd0);
        issue(72'd3, 72'd5, 144'd15, 1'b1);
        wait_out();
        @(posedge clk); #1;

        // random back-to-back pairs against a full-width reference multiply
        for (int k = 0; k < 1000; k++) begin
            ra = {$urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom};
            issue(ra[71:0], rb[71:0], 144'(ra[71:0]) * 144'(rb[71:0]), 1'b1);
        end
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 144'(exp_q.size()), 144'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
